// File: rtl/axi_hp_rd_arbiter_if.sv
// Bus bundles for the HP read arbiter.
//   axi_hp_rd_req_if : the two requester-side AR/R channels (packed per requester)
//   axi_hp_rd_hp_if  : the single AR/R channel towards the PS AXI_HP port
// Signal suffixes are relative to the arbiter (_i = into arbiter, _o = out of it).
interface axi_hp_rd_req_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int LEN_W  = 4
);
    logic [1:0]          s_arvalid_i;
    logic [1:0]          s_arready_o;
    logic [2*ADDR_W-1:0] s_araddr_i;
    logic [2*LEN_W-1:0]  s_arlen_i;
    logic [5:0]          s_arsize_i;
    logic [1:0]          s_rvalid_o;
    logic [1:0]          s_rready_i;
    logic [DATA_W-1:0]   s_rdata_o;
    logic [1:0]          s_rresp_o;
    logic                s_rlast_o;

    // requesters drive AR and R-ready
    modport master (
        output s_arvalid_i, s_araddr_i, s_arlen_i, s_arsize_i, s_rready_i,
        input  s_arready_o, s_rvalid_o, s_rdata_o, s_rresp_o, s_rlast_o
    );
    // arbiter view
    modport slave (
        input  s_arvalid_i, s_araddr_i, s_arlen_i, s_arsize_i, s_rready_i,
        output s_arready_o, s_rvalid_o, s_rdata_o, s_rresp_o, s_rlast_o
    );
endinterface

interface axi_hp_rd_hp_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int LEN_W  = 4,
    parameter int ID_W   = 6
);
    logic              m_arvalid_o;
    logic              m_arready_i;
    logic [ADDR_W-1:0] m_araddr_o;
    logic [LEN_W-1:0]  m_arlen_o;
    logic [2:0]        m_arsize_o;
    logic [1:0]        m_arburst_o;
    logic [ID_W-1:0]   m_arid_o;
    logic              m_rvalid_i;
    logic              m_rready_o;
    logic [DATA_W-1:0] m_rdata_i;
    logic [1:0]        m_rresp_i;
    logic              m_rlast_i;
    logic [ID_W-1:0]   m_rid_i;

    // arbiter view
    modport master (
        output m_arvalid_o, m_araddr_o, m_arlen_o, m_arsize_o, m_arburst_o, m_arid_o, m_rready_o,
        input  m_arready_i, m_rvalid_i, m_rdata_i, m_rresp_i, m_rlast_i, m_rid_i
    );
    // HP port view
    modport slave (
        input  m_arvalid_o, m_araddr_o, m_arlen_o, m_arsize_o, m_arburst_o, m_arid_o, m_rready_o,
        output m_arready_i, m_rvalid_i, m_rdata_i, m_rresp_i, m_rlast_i, m_rid_i
    );
endinterface

// File: rtl/axi_hp_rd_arbiter.sv
// Two-requester round-robin read arbiter for one PS AXI_HP read port.
// One burst in flight at a time, so R beats always belong to the current grant.
// Checks beat count and RID per burst; errors collect in a sticky flag.
// Optional macro ARB_PERF_CNT_EN adds saturating per-requester grant counters.
module axi_hp_rd_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int LEN_W  = 4,
    parameter int ID_W   = 6,
    parameter int CNT_W  = 32
) (
    input  logic              clk_i,
    input  logic              rst_i,
    axi_hp_rd_req_if.slave    s,
    axi_hp_rd_hp_if.master    m,
    output logic              grant_o,
    output logic              busy_o,
    output logic              err_o,
`ifdef ARB_PERF_CNT_EN
    output logic [CNT_W-1:0]  gnt_cnt0_o,
    output logic [CNT_W-1:0]  gnt_cnt1_o,
`endif
    input  logic              err_clr_i
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] ADDR = 2'd1;
    localparam logic [1:0] DATA = 2'd2;

    logic [1:0]        state_q, state_d;
    logic              last_q, last_d;
    logic              gnt_q, gnt_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [LEN_W-1:0]  len_q, len_d;
    logic [2:0]        size_q, size_d;
    logic [LEN_W:0]    beat_q, beat_d;
    logic              err_q, err_d;

    logic req_any, g_sel, ar_hs, in_data, r_hs, err_set;

    // Both requesting: alternate against the last winner; otherwise the lone requester wins.
    assign req_any = |s.s_arvalid_i;
    assign g_sel   = (&s.s_arvalid_i) ? ~last_q : s.s_arvalid_i[1];
    assign ar_hs   = (state_q == IDLE) && req_any;
    assign in_data = (state_q == DATA);

    // Requester side: ready only in IDLE; R is broadcast, valid steered to the grant.
    assign s.s_arready_o = (ar_hs && !rst_i) ? (g_sel ? 2'b10 : 2'b01) : 2'b00;
    assign s.s_rvalid_o  = (in_data && m.m_rvalid_i) ? (gnt_q ? 2'b10 : 2'b01) : 2'b00;
    assign s.s_rdata_o   = m.m_rdata_i;
    assign s.s_rresp_o   = m.m_rresp_i;
    assign s.s_rlast_o   = m.m_rlast_i;

    // HP side: AR comes straight from the captured registers.
    assign m.m_arvalid_o = (state_q == ADDR);
    assign m.m_araddr_o  = addr_q;
    assign m.m_arlen_o   = len_q;
    assign m.m_arsize_o  = size_q;
    assign m.m_arburst_o = 2'b01;
    assign m.m_arid_o    = ID_W'(gnt_q);
    assign m.m_rready_o  = in_data && s.s_rready_i[gnt_q];

    assign r_hs = in_data && m.m_rvalid_i && m.m_rready_o;

    // beat_q counts beats already accepted, so a well-formed last beat sees beat_q == arlen.
    assign err_set = r_hs && (( m.m_rlast_i && (beat_q != {1'b0, len_q})) ||
                              (!m.m_rlast_i && (beat_q >= {1'b0, len_q})) ||
                              (m.m_rid_i != m.m_arid_o));

    // Flag shows up in the offending handshake cycle and then holds.
    assign err_o   = err_q || err_set;
    assign err_d   = err_set ? 1'b1 : (err_clr_i ? 1'b0 : err_q);
    assign grant_o = gnt_q;
    assign busy_o  = (state_q != IDLE);

    // Next-state: grant/capture in IDLE, wait for AR accept, count beats to rlast.
    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        gnt_d   = gnt_q;
        addr_d  = addr_q;
        len_d   = len_q;
        size_d  = size_q;
        beat_d  = beat_q;
        case (state_q)
            IDLE: begin
                if (req_any) begin
                    gnt_d   = g_sel;
                    last_d  = g_sel;
                    addr_d  = g_sel ? s.s_araddr_i[2*ADDR_W-1:ADDR_W] : s.s_araddr_i[ADDR_W-1:0];
                    len_d   = g_sel ? s.s_arlen_i[2*LEN_W-1:LEN_W]    : s.s_arlen_i[LEN_W-1:0];
                    size_d  = g_sel ? s.s_arsize_i[5:3]               : s.s_arsize_i[2:0];
                    state_d = ADDR;
                end
            end
            ADDR: begin
                if (m.m_arready_i) begin
                    beat_d  = '0;
                    state_d = DATA;
                end
            end
            DATA: begin
                if (r_hs) begin
                    // saturate so a runaway burst keeps reporting overrun
                    if (!(&beat_q)) beat_d = beat_q + 1'b1;
                    if (m.m_rlast_i) state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and captured AR registers; last grant starts at 1 so requester 0 wins first.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            last_q  <= 1'b1;
            gnt_q   <= 1'b0;
            addr_q  <= '0;
            len_q   <= '0;
            size_q  <= '0;
            beat_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            gnt_q   <= gnt_d;
            addr_q  <= addr_d;
            len_q   <= len_d;
            size_q  <= size_d;
            beat_q  <= beat_d;
            err_q   <= err_d;
        end
    end

`ifdef ARB_PERF_CNT_EN
    logic [CNT_W-1:0] cnt0_q, cnt0_d, cnt1_q, cnt1_d;

    assign cnt0_d = err_clr_i ? '0 :
                    (ar_hs && !g_sel && !(&cnt0_q)) ? cnt0_q + 1'b1 : cnt0_q;
    assign cnt1_d = err_clr_i ? '0 :
                    (ar_hs &&  g_sel && !(&cnt1_q)) ? cnt1_q + 1'b1 : cnt1_q;
    assign gnt_cnt0_o = cnt0_q;
    assign gnt_cnt1_o = cnt1_q;

    // Saturating grant counters, cleared together with the error flag.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt0_q <= '0;
            cnt1_q <= '0;
        end else begin
            cnt0_q <= cnt0_d;
            cnt1_q <= cnt1_d;
        end
    end
`endif

endmodule
